seq_tally: RTL and testbench
============================

# seq_tally

Downstream consumer of the 1-2-3 sequence detector's `ans` level output, running on the same clock. Converts each rising edge of `ans` into a one-cycle `hit` pulse and counts detections in two-digit BCD (00–99) with a sticky overflow flag. An optional multiplexed 7-segment driver shows the tally on a two-digit display.

## Interface
- `SCAN_DIV`, 50000: clock cycles per display digit slot; legal range ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ans`  in  1  detector output level; same clock domain, sampled directly with no synchronizer.
- `clr`  in  1  synchronous clear of tally and overflow.
- `hold`  in  1  freeze tally; edges are still detected and `hit` still pulses.
- `hit`  out  1  one-cycle pulse per qualified rising edge of `ans`.
- `bcd_tens`  out  4  tens digit, 0–9.
- `bcd_ones`  out  4  ones digit, 0–9.
- `ovf`  out  1  sticky; set when the tally wraps 99→00.
- `an`  out  2  digit enables, active-low; `an[0]` = ones, `an[1]` = tens.
- `seg`  out  7  segments, active-low, bit order {g,f,e,d,c,b,a}.

## Operation
- Edge FSM, 2-bit register, three states:
  - ARM: reset state. Go to LOW when `ans`=0; otherwise stay.
  - LOW: go to HIGH when `ans`=1.
  - HIGH: go to LOW when `ans`=0.
- ARM blocks a spurious count when `ans` is already high at reset release.
- A hit event is the transition LOW→HIGH; `hit` is registered and high for exactly the cycle after that edge.
- Tally updates on a hit event, in priority order:
  - `clr`=1: tens=0, ones=0, ovf=0. The hit is discarded, but `hit` still pulses.
  - else `hold`=1: no change.
  - else ones<9: ones+1.
  - else ones=9, tens<9: ones=0, tens+1.
  - else (99): wrap to 00 and set ovf=1.
- `clr` without a hit event clears the same way. `clr` never affects the FSM or the scan logic.
- `ovf` stays set until `clr` or reset.
- BCD digits never take values 10–15.

## Timing
- Reset values:
  - FSM = ARM; hit=0, bcd_tens=0, bcd_ones=0, ovf=0.
  - Scan counter=0, an=2'b10, seg = pattern for 0 (7'b1000000) when the macro is defined.
- Latency: `ans` sampled high at edge k (FSM in LOW) → at edge k, FSM=HIGH, hit=1, and digits update. Edge k+1 → hit=0.
- Minimum spacing: `ans` must be low for at least one sampling edge between hits. A one-cycle low gap counts, so back-to-back hits are possible every 2 cycles.
- `rst_n` asserted mid-operation: all registers return to reset values immediately, asynchronously. After deassertion, the FSM requires `ans`=0 before the next hit.

## Configuration
- Macro `SEQ_TALLY_SEG_EN`.
- When defined:
  - A scan counter runs 0..SCAN_DIV-1, then wraps.
  - On wrap, the selected digit toggles: `an` alternates 2'b10 (ones) / 2'b01 (tens).
  - `seg` shows the selected digit through a combinational BCD→7-seg decode (0–9).
- When undefined:
  - No scan logic is present.
  - `an` is tied to 2'b11 and `seg` to 7'b1111111 (display dark).
  - All other behaviour is identical.

## Test plan
- Reset with `ans`=1 held for 5 cycles, then 0 for 1 cycle, then 1 → exactly one `hit`, one cycle wide; tally = 01.
- 12 pulses of `ans` (2 cycles high, 2 low) → tally reads tens=1, ones=2; `hit` count = 12; ovf=0.
- 100 pulses from 00 → tally = 00 and ovf=1. A further pulse → 01 with ovf still 1. Then `clr` → 00, ovf=0.
- `clr` asserted in the same cycle as a hit event from tally 37 → `hit` pulses; tally = 00.
- `hold`=1 across 3 pulses from 05 → three `hit` pulses; tally stays 05. Release `hold` and send 1 pulse → 06.
- With `SEQ_TALLY_SEG_EN`, SCAN_DIV=4, tally 42:
  - `an` toggles every 4 cycles.
  - `an`=2'b10 shows `seg`=7'b0100100 (digit 2); `an`=2'b01 shows `seg`=7'b0011001 (digit 4).
  - Assert `rst_n` mid-scan → an=2'b10, tally 00.

Source files
------------

// File: rtl/seq_tally_if.sv
// Bundle of the detector-consumer signals between seq_tally and its environment.
// The master side drives ans/clr/hold and observes the tally and display outputs.
interface seq_tally_if;
    logic       ans;
    logic       clr;
    logic       hold;
    logic       hit;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       ovf;
    logic [1:0] an;
    logic [6:0] seg;

    modport master (
        output ans, clr, hold,
        input  hit, bcd_tens, bcd_ones, ovf, an, seg
    );

    modport slave (
        input  ans, clr, hold,
        output hit, bcd_tens, bcd_ones, ovf, an, seg
    );
endinterface

// File: rtl/seq_tally.sv
// Rising-edge hit detector and two-digit BCD tally with sticky overflow.
// Define SEQ_TALLY_SEG_EN to add the multiplexed 7-segment display driver.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_ARM  | after reset; waits for ans=0 so a level high at release is not counted
// ST_LOW  | ans seen low; the next high sample is a hit
// ST_HIGH | ans high and already counted; waits for ans=0
module seq_tally #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_tally_if.slave  bus
);

    localparam logic [1:0] ST_ARM  = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    if (SCAN_DIV < 2) begin : g_scan_div_chk
        $error("seq_tally: SCAN_DIV must be at least 2");
    end

    logic [1:0] state, state_nxt;
    logic       hit_evt;
    logic       hit_q;
    logic [3:0] tens_q, ones_q;
    logic       ovf_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARM:  if (!bus.ans) state_nxt = ST_LOW;
            ST_LOW:  if (bus.ans)  state_nxt = ST_HIGH;
            ST_HIGH: if (!bus.ans) state_nxt = ST_LOW;
            default: state_nxt = ST_ARM;
        endcase
    end

    assign hit_evt = (state == ST_LOW) && bus.ans;

    // clr wins over everything, including a simultaneous hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_ARM;
            hit_q  <= 1'b0;
            tens_q <= 4'd0;
            ones_q <= 4'd0;
            ovf_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            hit_q <= hit_evt;
            if (bus.clr) begin
                tens_q <= 4'd0;
                ones_q <= 4'd0;
                ovf_q  <= 1'b0;
            end else if (hit_evt && !bus.hold) begin
                if (ones_q != 4'd9) begin
                    ones_q <= ones_q + 4'd1;
                end else begin
                    ones_q <= 4'd0;
                    if (tens_q != 4'd9) begin
                        tens_q <= tens_q + 4'd1;
                    end else begin
                        tens_q <= 4'd0;
                        ovf_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.hit      = hit_q;
    assign bus.bcd_tens = tens_q;
    assign bus.bcd_ones = ones_q;
    assign bus.ovf      = ovf_q;

`ifdef SEQ_TALLY_SEG_EN
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] scan_cnt;
    logic          sel_tens;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            sel_tens <= 1'b0;
        end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            sel_tens <= ~sel_tens;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign bus.an  = sel_tens ? 2'b01 : 2'b10;
    assign bus.seg = seg7(sel_tens ? tens_q : ones_q);
`else
    assign bus.an  = 2'b11;
    assign bus.seg = 7'b1111111;
`endif

endmodule

// File: tb/tb_seq_tally.sv
// Directed, table-driven check of seq_tally edge detection, BCD tally and display scan.
module tb_seq_tally;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   hit_cnt = 0;

    seq_tally_if bus();

    seq_tally #(.SCAN_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ans;
        logic       clr;
        logic       hold;
        logic       hit;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       ovf;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic a, input logic c, input logic h,
                                input logic eh, input int et, input int eo, input logic ev);
        vec_t v;
        v.ans = a; v.clr = c; v.hold = h; v.hit = eh;
        v.tens = 4'(et); v.ones = 4'(eo); v.ovf = ev;
        return v;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] lut [10];
        lut[0] = 7'b1000000; lut[1] = 7'b1111001; lut[2] = 7'b0100100;
        lut[3] = 7'b0110000; lut[4] = 7'b0011001; lut[5] = 7'b0010010;
        lut[6] = 7'b0000010; lut[7] = 7'b1111000; lut[8] = 7'b0000000;
        lut[9] = 7'b0010000;
        return lut[d];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.hit === 1'b1) hit_cnt++;
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            bus.ans = 1'b1;
            repeat (hi) tick();
            bus.ans = 1'b0;
            repeat (lo) tick();
        end
    endtask

    task automatic do_clr();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
    endtask

    task automatic chk_tally(input string name, input int t, input int o, input logic v);
        chk({name, " tens"}, 32'(bus.bcd_tens), 32'(t));
        chk({name, " ones"}, 32'(bus.bcd_ones), 32'(o));
        chk({name, " ovf"},  32'(bus.ovf),      32'(v));
    endtask

    initial begin
        logic [1:0] cur_an;
        logic [1:0] prev_an;
        bit         found;

        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 0, 1, 0, 1, 0);
        tbl[7]  = mk(1, 0, 0, 0, 0, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0);
        tbl[9]  = mk(1, 0, 0, 1, 0, 2, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 2, 0);
        tbl[11] = mk(1, 0, 0, 1, 0, 3, 0);
        tbl[12] = mk(0, 1, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 0, 1, 1, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(1, 0, 0, 1, 0, 1, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 1, 0);
        tbl[17] = mk(1, 1, 0, 1, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0);

        bus.ans = 1'b1;
        bus.clr = 1'b0;
        bus.hold = 1'b0;

        #12;
        chk("reset hit", 32'(bus.hit), 32'd0);
        chk_tally("reset", 0, 0, 1'b0);
`ifdef SEQ_TALLY_SEG_EN
        chk("reset an", 32'(bus.an), 32'(2'b10));
        chk("reset seg", 32'(bus.seg), 32'(7'b1000000));
`else
        chk("reset an", 32'(bus.an), 32'(2'b11));
        chk("reset seg", 32'(bus.seg), 32'(7'b1111111));
`endif
        #5 rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            bus.ans  = tbl[i].ans;
            bus.clr  = tbl[i].clr;
            bus.hold = tbl[i].hold;
            tick();
            chk($sformatf("vec%0d hit", i), 32'(bus.hit), 32'(tbl[i].hit));
            chk_tally($sformatf("vec%0d", i), int'(tbl[i].tens), int'(tbl[i].ones), tbl[i].ovf);
        end
        bus.clr = 1'b0;
        bus.hold = 1'b0;
        bus.ans = 1'b0;

        // 12 pulses, 2 high / 2 low
        do_clr();
        hit_cnt = 0;
        pulses(12, 2, 2);
        chk("p12 hits", 32'(hit_cnt), 32'd12);
        chk_tally("p12", 1, 2, 1'b0);

        // 100 pulses wrap to 00 with overflow, then one more, then clear
        do_clr();
        pulses(100, 1, 1);
        chk_tally("wrap", 0, 0, 1'b1);
        pulses(1, 1, 1);
        chk_tally("wrap+1", 0, 1, 1'b1);
        do_clr();
        chk_tally("wrap clr", 0, 0, 1'b0);

        // clr coincident with a hit from 37
        pulses(37, 1, 1);
        chk_tally("t37", 3, 7, 1'b0);
        bus.ans = 1'b1;
        bus.clr = 1'b1;
        tick();
        chk("clr+hit hit", 32'(bus.hit), 32'd1);
        chk_tally("clr+hit", 0, 0, 1'b0);
        bus.clr = 1'b0;
        bus.ans = 1'b0;
        tick();
        chk("clr+hit width", 32'(bus.hit), 32'd0);

        // hold across 3 pulses from 05
        pulses(5, 2, 2);
        chk_tally("t05", 0, 5, 1'b0);
        bus.hold = 1'b1;
        hit_cnt = 0;
        pulses(3, 2, 2);
        chk("hold hits", 32'(hit_cnt), 32'd3);
        chk_tally("hold", 0, 5, 1'b0);
        bus.hold = 1'b0;
        pulses(1, 2, 2);
        chk_tally("unhold", 0, 6, 1'b0);

        // display scan at tally 42
        do_clr();
        pulses(42, 1, 1);
        chk_tally("t42", 4, 2, 1'b0);
`ifdef SEQ_TALLY_SEG_EN
        prev_an = bus.an;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (bus.an !== prev_an) found = 1'b1;
        end
        chk("scan toggle seen", 32'(found), 32'd1);
        cur_an = bus.an;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k % 4 == 0) cur_an = ~cur_an;
            chk($sformatf("scan an k%0d", k), 32'(bus.an), 32'(cur_an));
            chk($sformatf("scan seg k%0d", k), 32'(bus.seg),
                32'((cur_an == 2'b10) ? seg_of(2) : seg_of(4)));
        end
        @(posedge clk);
        #2;
`else
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("dark an", 32'(bus.an), 32'(2'b11));
            chk("dark seg", 32'(bus.seg), 32'(7'b1111111));
        end
        @(posedge clk);
        #2;
`endif

        // asynchronous reset mid-scan, then ARM must block a held-high ans
        bus.ans = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst hit", 32'(bus.hit), 32'd0);
        chk_tally("midrst", 0, 0, 1'b0);
`ifdef SEQ_TALLY_SEG_EN
        chk("midrst an", 32'(bus.an), 32'(2'b10));
`else
        chk("midrst an", 32'(bus.an), 32'(2'b11));
`endif
        #3 rst_n = 1'b1;
        hit_cnt = 0;
        repeat (3) tick();
        chk("arm blocks", 32'(hit_cnt), 32'd0);
        pulses(1, 1, 1);
        bus.ans = 1'b0;
        tick();
        chk_tally("rearm", 0, 0, 1'b0);
        bus.ans = 1'b1;
        tick();
        chk("rearm hit", 32'(bus.hit), 32'd1);
        chk_tally("rearm count", 0, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
